// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory and hazard/decode.
// Optional perf counters appear with FETCH_PERF_CNT_EN.
interface fetch_stage_if;
  logic        pc_write_enable;
  logic        if_id_write;
  logic        flush_pipeline;
  logic        pc_sel;
  logic [31:0] alu_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
  logic [31:0] fetch_count;
`endif

  modport master (
    input  pc_write_enable,
    input  if_id_write,
    input  flush_pipeline,
    input  pc_sel,
    input  alu_target,
    input  imem_rdata,
    output imem_addr,
    output if_id_pc,
    output if_id_pc4,
    output if_id_instr,
`ifdef FETCH_PERF_CNT_EN
    output stall_cycles,
    output flush_cycles,
    output fetch_count,
`endif
    output if_id_valid
  );

  modport slave (
    output pc_write_enable,
    output if_id_write,
    output flush_pipeline,
    output pc_sel,
    output alu_target,
    output imem_rdata,
    input  imem_addr,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_instr,
`ifdef FETCH_PERF_CNT_EN
    input  stall_cycles,
    input  flush_cycles,
    input  fetch_count,
`endif
    input  if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch: PC register, PC+4, redirect mux and IF/ID register.
// Define FETCH_PERF_CNT_EN to add stall/flush/fetch counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4      = pc + 32'd4;
  assign target        = bus.alu_target & ~32'd3;
  assign bus.imem_addr = pc;

  // Redirect beats a stall so a taken branch is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (bus.pc_sel) begin
      pc <= target;
    end else if (bus.pc_write_enable) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_id_pc    <= 32'd0;
      bus.if_id_pc4   <= 32'd0;
      bus.if_id_instr <= NOP_INSTR;
      bus.if_id_valid <= 1'b0;
    end else if (bus.flush_pipeline) begin
      bus.if_id_instr <= NOP_INSTR;
      bus.if_id_valid <= 1'b0;
    end else if (bus.if_id_write) begin
      bus.if_id_pc    <= pc;
      bus.if_id_pc4   <= pc_plus4;
      bus.if_id_instr <= bus.imem_rdata;
      bus.if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall_cycles <= 32'd0;
      bus.flush_cycles <= 32'd0;
      bus.fetch_count  <= 32'd0;
    end else begin
      if (!bus.pc_write_enable && !bus.pc_sel &&
          bus.stall_cycles != CNT_MAX) begin
        bus.stall_cycles <= bus.stall_cycles + 32'd1;
      end
      if (bus.flush_pipeline &&
          bus.flush_cycles != CNT_MAX) begin
        bus.flush_cycles <= bus.flush_cycles + 32'd1;
      end
      if (bus.if_id_write && !bus.flush_pipeline &&
          bus.fetch_count != CNT_MAX) begin
        bus.fetch_count <= bus.fetch_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus random checks of fetch_stage against a step model.
// Build with FETCH_PERF_CNT_EN to also check the counters.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid;
  longint      m_stall, m_flush, m_fetch;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ipc = 0; m_ipc4 = 0;
    m_instr = NOP; m_valid = 0;
    m_stall = 0; m_flush = 0; m_fetch = 0;
  endtask

  function automatic logic [31:0] sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".addr"}, bus.imem_addr, m_pc);
    chk({tag, ".pc"}, bus.if_id_pc, m_ipc);
    chk({tag, ".pc4"}, bus.if_id_pc4, m_ipc4);
    chk({tag, ".instr"}, bus.if_id_instr, m_instr);
    chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".stall"}, bus.stall_cycles, sat(m_stall));
    chk({tag, ".flush"}, bus.flush_cycles, sat(m_flush));
    chk({tag, ".fetch"}, bus.fetch_count, sat(m_fetch));
`endif
  endtask

  task automatic step(input logic pwe, input logic ifw, input logic fl,
                      input logic sel, input logic [31:0] tgt,
                      input string tag);
    logic [31:0] old;
    bus.pc_write_enable = pwe;
    bus.if_id_write     = ifw;
    bus.flush_pipeline  = fl;
    bus.pc_sel          = sel;
    bus.alu_target      = tgt;
    @(posedge clk);
    old = m_pc;
    if (!pwe && !sel) m_stall++;
    if (fl) m_flush++;
    if (ifw && !fl) m_fetch++;
    if (sel) m_pc = {tgt[31:2], 2'b00};
    else if (pwe) m_pc = old + 32'd4;
    if (fl) begin
      m_instr = NOP; m_valid = 0;
    end else if (ifw) begin
      m_ipc = old; m_ipc4 = old + 32'd4;
      m_instr = mem_word(old); m_valid = 1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.pc_write_enable = 0; bus.if_id_write = 0;
    bus.flush_pipeline = 0; bus.pc_sel = 0;
    bus.alu_target = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.addr100", bus.imem_addr, 32'h100);
    rst = 1'b0;

    step(1, 1, 0, 0, 0, "run0");
    chk("run0.pc", bus.if_id_pc, 32'h100);
    step(1, 1, 0, 0, 0, "run1");
    step(1, 1, 0, 0, 0, "run2");
    chk("run2.addr", bus.imem_addr, 32'h10C);
    chk("run2.pc", bus.if_id_pc, 32'h108);

    step(1, 1, 1, 1, 32'h18, "to18");
    step(1, 1, 0, 0, 0, "at1c");
    step(1, 1, 0, 0, 0, "at20");
    step(0, 0, 0, 0, 0, "stall0");
    step(0, 0, 0, 0, 0, "stall1");
    chk("stall.addr", bus.imem_addr, 32'h20);
    chk("stall.pc", bus.if_id_pc, 32'h1C);
    step(1, 1, 0, 0, 0, "resume");
    chk("resume.addr", bus.imem_addr, 32'h24);

    step(1, 1, 1, 1, 32'h40, "to40");
    step(1, 1, 1, 1, 32'h203, "redir");
    chk("redir.addr", bus.imem_addr, 32'h200);
    chk("redir.instr", bus.if_id_instr, NOP);
    step(1, 1, 0, 0, 0, "tgt");
    chk("tgt.pc", bus.if_id_pc, 32'h200);
    chk("tgt.valid", {31'd0, bus.if_id_valid}, 32'd1);

    step(0, 0, 1, 1, 32'h3000, "redir_stall");
    chk("rs.addr", bus.imem_addr, 32'h3000);

    step(1, 1, 1, 1, 32'hFFFF_FFFC, "toend");
    step(1, 1, 0, 0, 0, "wrap");
    chk("wrap.addr", bus.imem_addr, 32'h0);
    chk("wrap.pc4", bus.if_id_pc4, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic s;
      logic [31:0] t;
      s = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 3) == 0) ?
          32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           s | ($urandom_range(0, 9) == 0), s, t, "rand");
    end

    async_reset("rst1");
`ifdef FETCH_PERF_CNT_EN
    step(0, 0, 0, 0, 0, "p_st0");
    step(0, 0, 0, 0, 0, "p_st1");
    step(0, 0, 0, 0, 0, "p_st2");
    step(1, 1, 1, 1, 32'h80, "p_fl0");
    step(1, 1, 1, 1, 32'h90, "p_fl1");
    chk("perf.stall3", bus.stall_cycles, 32'd3);
    chk("perf.flush2", bus.flush_cycles, 32'd2);
    async_reset("rst2");
`endif
    step(1, 1, 0, 0, 0, "post");
    chk("post.pc", bus.if_id_pc, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
